// File: rtl/norm_pkg.sv
// Shared types and helpers for the iterative left-normalizer.
package norm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } norm_state_t;

    // Width of the slice tested by binary-search stage k.
    function automatic int stage_width(input int k);
        return 1 << k;
    endfunction

endpackage

// File: rtl/norm_shift.sv
// Iterative left-normalizer: binary search for the leading one, one stage per clock.
// Returns the normalized word and the shift amount (leading-zero count).
module norm_shift
    import norm_pkg::*;
#(
    parameter  int WIDTH       = 32,
    localparam int SHAMT_WIDTH = $clog2(WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [WIDTH-1:0]       i_data,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [WIDTH-1:0]       o_data,
    output logic [SHAMT_WIDTH-1:0] o_shamt,
    output logic                   o_zero
);

    norm_state_t            state_reg;
    logic [WIDTH-1:0]       work_reg;
    logic [SHAMT_WIDTH-1:0] acc_reg;
    logic [SHAMT_WIDTH-1:0] k_reg;

    logic [WIDTH-1:0]       stage_work [SHAMT_WIDTH];
    logic [SHAMT_WIDTH-1:0] stage_hit;
    logic [WIDTH-1:0]       work_next;
    logic [SHAMT_WIDTH-1:0] acc_next;

    // Every stage's test-and-shift is built; k_reg picks the one active this cycle.
    generate
        for (genvar gi = 0; gi < SHAMT_WIDTH; gi++) begin : g_stage
            localparam int SW = stage_width(gi);
            assign stage_hit[gi]  = (work_reg[WIDTH-1 -: SW] == '0);
            assign stage_work[gi] = stage_hit[gi] ? (work_reg << SW) : work_reg;
        end
    endgenerate

    always_comb begin
        work_next        = stage_work[k_reg];
        acc_next         = acc_reg;
        acc_next[k_reg]  = stage_hit[k_reg];
    end

    assign i_ready = (state_reg == IDLE);
    assign o_valid = (state_reg == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            work_reg  <= '0;
            acc_reg   <= '0;
            k_reg     <= '0;
            o_data    <= '0;
            o_shamt   <= '0;
            o_zero    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_valid) begin
                        work_reg  <= i_data;
                        acc_reg   <= '0;
                        k_reg     <= SHAMT_WIDTH'(SHAMT_WIDTH - 1);
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    work_reg <= work_next;
                    acc_reg  <= acc_next;
                    if (k_reg == '0) begin
                        o_data    <= work_next;
                        o_shamt   <= acc_next;
                        o_zero    <= (work_next == '0);
                        state_reg <= DONE;
                    end else begin
                        k_reg <= k_reg - 1'b1;
                    end
                end
                DONE: begin
                    if (o_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_norm_shift.sv
// Directed bench for norm_shift at WIDTH = 32: latency, results, backpressure, reset abort.
module tb_norm_shift;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk     = 1'b0;
    logic             rst     = 1'b1;
    logic             i_valid = 1'b0;
    logic             i_ready;
    logic [WIDTH-1:0] i_data  = '0;
    logic             o_valid;
    logic             o_ready = 1'b1;
    logic [WIDTH-1:0] o_data;
    logic [SHW-1:0]   o_shamt;
    logic             o_zero;

    int checks = 0;
    int errors = 0;

    norm_shift #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_shamt (o_shamt),
        .o_zero  (o_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Present a word in IDLE and let the next edge take it.
    task automatic accept(input logic [31:0] d, input bit hold);
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = d;
        @(posedge clk);
        #1;
        if (!hold) i_valid = 1'b0;
        check("accept_ready_low", {31'd0, i_ready}, 32'd0);
    endtask

    // Count edges after acceptance until o_valid rises (bounded).
    task automatic wait_result(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!o_valid && n < 20);
        check({tag, "_latency"}, n, SHW);
    endtask

    task automatic expect_result(input string tag, input logic [31:0] d,
                                 input logic [4:0] sh, input logic z);
        check({tag, "_data"},  o_data, d);
        check({tag, "_shamt"}, {27'd0, o_shamt}, {27'd0, sh});
        check({tag, "_zero"},  {31'd0, o_zero}, {31'd0, z});
        $display("txn %s: data=0x%08h shamt=%0d zero=%0d", tag, o_data, o_shamt, o_zero);
    endtask

    // With o_ready high, the next edge completes the output handshake.
    task automatic handshake(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_valid_fall"}, {31'd0, o_valid}, 32'd0);
        check({tag, "_ready_idle"}, {31'd0, i_ready}, 32'd1);
    endtask

    task automatic run_word(input string tag, input logic [31:0] d_in,
                            input logic [31:0] d, input logic [4:0] sh, input logic z);
        accept(d_in, 1'b0);
        wait_result(tag);
        expect_result(tag, d, sh, z);
        handshake(tag);
    endtask

    initial begin
        // Reset values while rst is held, with an input that must be ignored.
        i_valid = 1'b1;
        i_data  = 32'h1234_5678;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_ready", {31'd0, i_ready}, 32'd1);
        check("rst_data",  o_data, 32'd0);
        check("rst_shamt", {27'd0, o_shamt}, 32'd0);
        check("rst_zero",  {31'd0, o_zero}, 32'd0);
        @(negedge clk);
        i_valid = 1'b0;
        rst     = 1'b0;

        run_word("one",  32'h0000_0001, 32'h8000_0000, 5'd31, 1'b0);
        run_word("msb",  32'h8000_0000, 32'h8000_0000, 5'd0,  1'b0);
        run_word("mid",  32'h0001_2345, 32'h91A2_8000, 5'd15, 1'b0);
        run_word("zero", 32'h0000_0000, 32'h0000_0000, 5'd31, 1'b1);

        // Backpressure with a second word waiting on the input.
        o_ready = 1'b0;
        accept(32'h0000_00FF, 1'b1);
        i_data = 32'h00F0_0000;
        wait_result("bp1");
        expect_result("bp1", 32'hFF00_0000, 5'd24, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", {31'd0, o_valid}, 32'd1);
            check("bp_hold_ready", {31'd0, i_ready}, 32'd0);
            check("bp_hold_data",  o_data, 32'hFF00_0000);
            check("bp_hold_shamt", {27'd0, o_shamt}, 32'd24);
        end
        @(negedge clk);
        o_ready = 1'b1;
        handshake("bp1");
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        check("bp2_accepted", {31'd0, i_ready}, 32'd0);
        wait_result("bp2");
        expect_result("bp2", 32'hF000_0000, 5'd8, 1'b0);
        handshake("bp2");

        // Abort mid-RUN with an asynchronous reset.
        accept(32'h0000_0003, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_valid", {31'd0, o_valid}, 32'd0);
        check("abort_ready", {31'd0, i_ready}, 32'd1);
        check("abort_data",  o_data, 32'd0);
        check("abort_shamt", {27'd0, o_shamt}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_word("post_rst", 32'h0000_0400, 32'h8000_0000, 5'd21, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
